// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the single write port of the register file.
// Round-robin shares it between the ALU (req0) and load (req1) write-back
// paths, and runs a clear sequence over CLR_FIRST..NUM_REGS-1 on command.
// Every register-file write control leaves this block registered.
module rf_write_arbiter #(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          NUM_REGS  = 16,
    parameter int unsigned          CLR_FIRST = 1,
    parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr_start,
    output logic                          clr_busy,
    output logic                          clr_done,
    input  logic                          v0,
    input  logic [$clog2(NUM_REGS)-1:0]   rd0,
    input  logic [DATA_W-1:0]             d0,
    output logic                          rdy0,
    input  logic                          v1,
    input  logic [$clog2(NUM_REGS)-1:0]   rd1,
    input  logic [DATA_W-1:0]             d1,
    output logic                          rdy1,
    output logic                          rf_n_w,
    output logic [$clog2(NUM_REGS)-1:0]   rf_rd,
    output logic [DATA_W-1:0]             rf_data
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    // One extra bit so the counter can never wrap back into the index range
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        ARB,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       clr_cnt_q, clr_cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                rf_n_w_q, rf_n_w_d;
    logic [AW-1:0]       rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic                clr_done_q, clr_done_d;
    logic                clr_last;
    logic                gnt0, gnt1;

    assign clr_last = (clr_cnt_q == CW'(NUM_REGS - 1));

    // State, counter, arbitration history and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            rf_n_w_q     <= 1'b1;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            last_grant_q <= last_grant_d;
            rf_n_w_q     <= rf_n_w_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
            clr_done_q   <= clr_done_d;
        end
    end

    // Next state: a clear request preempts arbitration; CLEAR ends on the last index
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = CW'(CLR_FIRST);
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_last) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Outputs: grants, and next values of the registered write port
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_grant_d = last_grant_q;
        rf_n_w_d     = 1'b1;
        rf_rd_d      = rf_rd_q;
        rf_data_d    = rf_data_q;
        clr_done_d   = 1'b0;

        if (state_q == CLEAR) begin
            rf_n_w_d   = 1'b0;
            rf_rd_d    = clr_cnt_q[AW-1:0];
            rf_data_d  = CLR_VALUE;
            clr_done_d = clr_last;
        end else if (!clr_start) begin
            // Round-robin history only moves when both requesters contend
            if (v0 && v1) begin
                gnt0         = last_grant_q;
                gnt1         = !last_grant_q;
                last_grant_d = !last_grant_q;
            end else begin
                gnt0 = v0;
                gnt1 = v1;
            end

            // Writes addressed to r0 complete the handshake but are dropped
            if (gnt0 && (rd0 != '0)) begin
                rf_n_w_d  = 1'b0;
                rf_rd_d   = rd0;
                rf_data_d = d0;
            end else if (gnt1 && (rd1 != '0)) begin
                rf_n_w_d  = 1'b0;
                rf_rd_d   = rd1;
                rf_data_d = d1;
            end
        end
    end

    assign rdy0     = gnt0;
    assign rdy1     = gnt1;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign rf_n_w   = rf_n_w_q;
    assign rf_rd    = rf_rd_q;
    assign rf_data  = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized and directed stimulus for rf_write_arbiter.
// The driver predicts every register-file write into a queue; an independent
// monitor pops and compares whenever the write port is active.
module tb_rf_write_arbiter;

    localparam int unsigned NREG  = 16;
    localparam int unsigned CLR_F = 1;

    typedef struct {
        logic [3:0] rd;
        logic [7:0] data;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_start;
    logic       clr_busy, clr_done;
    logic       v0, v1, rdy0, rdy1;
    logic [3:0] rd0, rd1, rf_rd;
    logic [7:0] d0, d1, rf_data;
    logic       rf_n_w;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        exp_q[$];

    // Reference model state
    int unsigned m_clr_left;   // CLEAR cycles still to run
    bit          m_prefer0;    // req0 wins the next contention
    int unsigned m_done_exp;
    int unsigned obs_done;

    rf_write_arbiter #(
        .DATA_W   (8),
        .NUM_REGS (NREG),
        .CLR_FIRST(CLR_F),
        .CLR_VALUE(8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clr_start(clr_start),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .v0       (v0),
        .rd0      (rd0),
        .d0       (d0),
        .rdy0     (rdy0),
        .v1       (v1),
        .rd1      (rd1),
        .d1       (d1),
        .rdy1     (rdy1),
        .rf_n_w   (rf_n_w),
        .rf_rd    (rf_rd),
        .rf_data  (rf_data)
    );

    always #5 clk = ~clk;

    // Monitor: every active write must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!rf_n_w) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got rd=%0d data=%h done=%0b, want no write",
                             rf_rd, rf_data, clr_done);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rf_rd !== e.rd || rf_data !== e.data || clr_done !== e.done) begin
                        errors++;
                        $display("FAIL rf_write got rd=%0d data=%h done=%0b, want rd=%0d data=%h done=%0b",
                                 rf_rd, rf_data, clr_done, e.rd, e.data, e.done);
                    end
                end
            end else if (clr_done !== 1'b0) begin
                errors++;
                $display("FAIL done_without_write got clr_done=%0b, want 0", clr_done);
            end
            if (clr_done === 1'b1) obs_done++;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // One bus cycle: drive inputs, predict grants and writes, check handshake
    task automatic cycle(input bit a0, input logic [3:0] r0, input logic [7:0] x0,
                         input bit a1, input logic [3:0] r1, input logic [7:0] x1,
                         input bit cs, output bit g0, output bit g1);
        bit e_busy;
        @(negedge clk);
        v0 = a0; rd0 = r0; d0 = x0;
        v1 = a1; rd1 = r1; d1 = x1;
        clr_start = cs;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        e_busy = (m_clr_left > 0);
        if (m_clr_left > 0) begin
            m_clr_left--;
        end else if (cs) begin
            for (int unsigned k = CLR_F; k < NREG; k++)
                exp_q.push_back('{rd: 4'(k), data: 8'h00, done: (k == NREG - 1)});
            m_clr_left = NREG - CLR_F;
            m_done_exp++;
        end else if (a0 && a1) begin
            g0 = m_prefer0;
            g1 = !m_prefer0;
            m_prefer0 = !m_prefer0;
        end else begin
            g0 = a0;
            g1 = a1;
        end
        if (g0 && r0 != 4'd0) exp_q.push_back('{rd: r0, data: x0, done: 1'b0});
        if (g1 && r1 != 4'd0) exp_q.push_back('{rd: r1, data: x1, done: 1'b0});
        check("rdy0", {7'd0, rdy0}, {7'd0, g0});
        check("rdy1", {7'd0, rdy1}, {7'd0, g1});
        check("clr_busy", {7'd0, clr_busy}, {7'd0, e_busy});
    endtask

    task automatic idle(input int unsigned n);
        bit g0, g1;
        for (int unsigned i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, g0, g1);
    endtask

    initial begin
        bit          g0, g1, p0, p1;
        logic [3:0]  pr0, pr1;
        logic [7:0]  pd0, pd1;
        int unsigned blocked;

        reset = 1'b1; clr_start = 1'b0;
        v0 = 1'b0; rd0 = '0; d0 = '0;
        v1 = 1'b0; rd1 = '0; d1 = '0;
        m_clr_left = 0; m_prefer0 = 1'b1; m_done_exp = 0; obs_done = 0;
        @(negedge clk); #1;
        check("reset_n_w", {7'd0, rf_n_w}, 8'd1);
        check("reset_rd", {4'd0, rf_rd}, 8'd0);
        check("reset_data", rf_data, 8'd0);
        check("reset_busy", {7'd0, clr_busy}, 8'd0);
        check("reset_done", {7'd0, clr_done}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single write, then contention, then a dropped r0 write
        cycle(1, 4'd3, 8'hA5, 0, 0, 0, 0, g0, g1);
        idle(2);
        for (int i = 0; i < 4; i++) cycle(1, 4'd2, 8'h11, 1, 4'd5, 8'h22, 0, g0, g1);
        cycle(0, 0, 0, 1, 4'd0, 8'hFF, 0, g0, g1);
        idle(2);

        // Clear beats a pending req0, which lands in the first ARB cycle
        blocked = 0;
        cycle(1, 4'd4, 8'h3C, 0, 0, 0, 1, g0, g1);
        while (rdy0 !== 1'b1 && blocked < 40) begin
            blocked++;
            cycle(1, 4'd4, 8'h3C, 0, 0, 0, 0, g0, g1);
        end
        check("clr_block_cycles", 8'(blocked), 8'd16);
        idle(2);

        // Reset aborts a clear after r7 has been written
        cycle(0, 0, 0, 0, 0, 0, 1, g0, g1);
        idle(7);
        @(negedge clk); #1;
        check("abort_at_rd", {4'd0, rf_rd}, 8'd7);
        #1 reset = 1'b1;
        #1;
        check("abort_n_w", {7'd0, rf_n_w}, 8'd1);
        check("abort_busy", {7'd0, clr_busy}, 8'd0);
        check("abort_done", {7'd0, clr_done}, 8'd0);
        exp_q.delete();
        m_clr_left = 0; m_prefer0 = 1'b1; m_done_exp--;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 1, g0, g1);
        idle(17);

        // clr_start held through CLEAR must not restart or extend it
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 0, 1, g0, g1);
        idle(3);

        // Randomized traffic with occasional clears
        p0 = 0; p1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 800; i++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; pr0 = 4'($urandom_range(0, 15)); pd0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1; pr1 = 4'($urandom_range(0, 15)); pd1 = 8'($urandom);
            end
            cycle(p0, pr0, pd0, p1, pr1, pd1, ($urandom_range(0, 99) < 3), g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        idle(20);

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        check("done_pulses", 8'(obs_done), 8'(m_done_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Owns the single write port of the 16x8 register file and shares it between two write-back requesters: req0 (ALU result) and req1 (memory load). It also runs a clear sequence on command, writing CLR_VALUE into every register from CLR_FIRST to NUM_REGS-1. All register-file write controls leave the block registered, so the register file sees exactly one clean write per cycle at most.

Parameters:
DATA_W, 8, register data width
NUM_REGS, 16, register count; address width is log2(NUM_REGS) = 4
CLR_FIRST, 1, first index written by the clear sequence; r0 is hardwired zero and is skipped
CLR_VALUE, 0, value written by the clear sequence

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
clr_start  in  1  one-cycle pulse that requests the clear sequence
clr_busy  out  1  high while in state CLEAR
clr_done  out  1  one-cycle pulse, registered with the last clear write
v0  in  1  req0 valid
rd0  in  4  req0 destination register
d0  in  8  req0 write data
rdy0  out  1  req0 accepted this cycle
v1  in  1  req1 valid
rd1  in  4  req1 destination register
d1  in  8  req1 write data
rdy1  out  1  req1 accepted this cycle
rf_n_w  out  1  register-file write enable, active-low, registered
rf_rd  out  4  register-file write address, registered
rf_data  out  8  register-file write data, registered

Behaviour:
- Reset (asynchronous, takes effect immediately at any point):
  - state=ARB, rf_n_w=1, rf_rd=0, rf_data=0, clr_busy=0, clr_done=0, clr_cnt=0.
  - last_grant=1, so req0 wins the first contention.
- Handshake:
  - A transfer happens on a rising edge where vN=1 and rdyN=1.
  - rdyN is combinational from the current state, v0, v1 and last_grant.
  - A requester holds vN, rdN and dN stable until it is accepted.
- State ARB, clr_start=1:
  - Move to CLEAR next edge; clr_cnt=CLR_FIRST.
  - rdy0=rdy1=0 in that cycle, so clear beats any pending requests.
- State ARB, clr_start=0:
  - Only one vN high: rdyN=1.
  - Both high: grant the requester not in last_grant; last_grant updates to the winner on acceptance.
  - Neither high: no grant, last_grant unchanged.
- Accepted write, rdN != 0:
  - Next edge: rf_n_w=0, rf_rd=rdN, rf_data=dN.
  - The register file captures it on the following edge; latency from acceptance to register update is 2 edges.
- Accepted write, rdN == 0:
  - The transfer completes (rdy high) but rf_n_w stays 1; writes to r0 are dropped.
- No accepted write in a cycle: rf_n_w=1 next edge; rf_rd and rf_data hold their previous values.
- State CLEAR:
  - rdy0=rdy1=0.
  - Each edge registers rf_n_w=0, rf_rd=clr_cnt, rf_data=CLR_VALUE, then clr_cnt increments.
  - On the edge that registers clr_cnt=NUM_REGS-1: set clr_done=1 for one cycle and return to ARB.
  - Total is NUM_REGS-CLR_FIRST consecutive writes (15 by default).
  - clr_start is ignored while in CLEAR.
- clr_busy=1 from the edge that enters CLEAR through the cycle in which the last clear write is registered.
- clr_cnt is log2(NUM_REGS)+1 bits wide; the terminal compare uses NUM_REGS-1, so the counter never wraps.
- Reset during CLEAR: the sequence aborts, no clr_done is issued, rf_n_w=1 immediately, state=ARB.
- last_grant is not changed by CLEAR; round-robin order resumes where it left off.

Test Plan:
- Reset, then v0=1 rd0=3 d0=8'hA5: rdy0=1 in the same cycle; next cycle rf_n_w=0 rf_rd=3 rf_data=A5; one cycle later rf_n_w=1.
- v0=v1=1 held for 4 cycles (rd0=2 d0=11, rd1=5 d1=22): grants go req0, req1, req0, req1; rf_rd sequence is 2, 5, 2, 5.
- v1=1 rd1=0 d1=FF: rdy1=1, rf_n_w stays 1 every cycle.
- clr_start pulse with v0=1 in the same cycle: rdy0=0 for 16 cycles (1 start cycle plus 15 CLEAR cycles); rf_rd walks 1..15 with rf_data=0 and rf_n_w=0; clr_done pulses with rf_rd=15; req0 is accepted in the first ARB cycle.
- Assert reset while rf_rd=7 during CLEAR: rf_n_w=1 and clr_busy=0 immediately, no clr_done; a new clr_start after reset restarts from r1.
- clr_start while clr_busy=1: ignored; exactly 15 writes occur and exactly one clr_done pulse.
